// File: rtl/spi_reg_slave.sv
// SPI mode-0 write-only register front end for the PWM peripheral.
// Synchronises raw SPI pins into clk, decodes 16-bit write frames, holds five control registers.
module spi_reg_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sclk,
    input  logic       spi_copi,
    input  logic       spi_cs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam int         NUM_REGS   = 5;
    localparam logic [4:0] FRAME_BITS = 5'd16;
    localparam logic [4:0] CNT_OVF    = 5'd17;
    localparam logic [6:0] ADDR_LIMIT = 7'(MAX_ADDR);

    logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, cs_sync;
    logic                   sclk_d, copi_d, cs_d;
    logic                   sclk_s, copi_s, cs_s;
    logic                   sclk_rise, cs_fall, cs_rise;

    state_t      state_q, next_state;
    logic [15:0] shift_q;
    logic [4:0]  bit_cnt;
    logic [7:0]  regs [NUM_REGS];
    logic        commit_wr, commit_err;

    // The cs chain resets to the asserted level so a frame already running
    // at reset release never produces a falling edge and is not accepted.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            copi_sync <= '0;
            cs_sync   <= '0;
            sclk_d    <= 1'b0;
            copi_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], spi_copi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            sclk_d    <= sclk_s;
            copi_d    <= copi_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state_q;
        commit_wr  = 1'b0;
        commit_err = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) next_state = SHIFT;
            SHIFT: begin
                if (cs_rise) begin
                    next_state = IDLE;
                    if (bit_cnt == FRAME_BITS)
                        commit_wr = shift_q[15] && (shift_q[14:8] <= ADDR_LIMIT);
                    else
                        commit_err = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: the register file is a handful of control flops, not RAM, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt   <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= commit_wr;
            frame_err <= commit_err;
            if (state_q == IDLE && cs_fall) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (state_q == SHIFT && !cs_rise && sclk_rise) begin
                shift_q <= {shift_q[14:0], copi_d};
                if (bit_cnt != CNT_OVF) bit_cnt <= bit_cnt + 5'd1;
            end
            if (commit_wr) begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (shift_q[14:8] == 7'(i)) regs[i] <= shift_q[7:0];
            end
        end
    end

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Self-checking bench for spi_reg_slave: directed frames plus randomized legal SPI timing,
// compared against a frame-level register model.
module tb_spi_reg_slave;

    localparam int SYNC = 2;
    localparam int MAXA = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sclk, spi_copi, spi_cs;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe, frame_err;

    spi_reg_slave #(.SYNC_STAGES(SYNC), .MAX_ADDR(MAXA)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi_sclk        (spi_sclk),
        .spi_copi        (spi_copi),
        .spi_cs          (spi_cs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         strobe_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] model_regs [5];

    // Cycle counts of each pulse output; a pulse wider than one cycle counts more than once.
    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s reg%0d", tag, i), 32'(dut_reg(i)), 32'(model_regs[i]));
    endtask

    // Sends nbits of value MSB first; reset_after>0 pulses rst_n after that many bits.
    task automatic spi_frame(input string tag, input logic [31:0] value, input int nbits,
                             input int half, input int gap, input int reset_after);
        int          s0, e0, first;
        bit          did_reset, exp_wr, exp_err;
        logic [15:0] f;
        f         = value[15:0];
        did_reset = 0;
        s0        = strobe_cnt;
        e0        = err_cnt;
        @(negedge clk);
        spi_cs = 1'b0;
        for (int b = nbits - 1; b >= 0; b--) begin
            spi_copi = value[b];
            repeat (half) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (half) @(negedge clk);
            spi_sclk = 1'b0;
            if (reset_after > 0 && (nbits - b) == reset_after) begin
                rst_n = 1'b0;
                #1;
                for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
                check_regs({tag, " in reset"});
                check({tag, " strobe in reset"}, 32'(wr_strobe), 32'd0);
                check({tag, " err in reset"}, 32'(frame_err), 32'd0);
                repeat (3) @(negedge clk);
                rst_n     = 1'b1;
                did_reset = 1;
                s0        = strobe_cnt;
                e0        = err_cnt;
            end
        end
        repeat (half) @(negedge clk);
        spi_cs = 1'b1;
        first  = 0;
        for (int c = 1; c <= gap; c++) begin
            @(negedge clk);
            if ((wr_strobe || frame_err) && first == 0) first = c;
        end
        exp_wr  = !did_reset && nbits == 16 && f[15] && int'(f[14:8]) <= MAXA;
        exp_err = !did_reset && nbits != 16;
        if (exp_wr) model_regs[int'(f[10:8])] = f[7:0];
        check({tag, " strobes"}, 32'(strobe_cnt - s0), exp_wr ? 32'd1 : 32'd0);
        check({tag, " errs"}, 32'(err_cnt - e0), exp_err ? 32'd1 : 32'd0);
        if (exp_wr || exp_err) check({tag, " latency"}, 32'(first), 32'(SYNC + 1));
        check_regs(tag);
    endtask

    task automatic idle_toggle(input int n);
        int s0, e0;
        s0 = strobe_cnt;
        e0 = err_cnt;
        for (int i = 0; i < n; i++) begin
            spi_copi = 1'($urandom);
            repeat (SYNC + 1) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (SYNC + 1) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (SYNC + 3) @(negedge clk);
        check("idle sclk strobes", 32'(strobe_cnt - s0), 32'd0);
        check("idle sclk errs", 32'(err_cnt - e0), 32'd0);
        check_regs("idle sclk");
    endtask

    initial begin
        int          half, gap, nbits, r;
        logic [31:0] value;
        rst_n    = 1'b0;
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_copi = 1'b0;
        for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_regs("reset");
        check("reset strobe", 32'(wr_strobe), 32'd0);
        check("reset err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        spi_frame("w0", 32'h80F0, 16, SYNC + 1, SYNC + 2, 0);
        spi_frame("w4", 32'h8480, 16, SYNC + 1, SYNC + 2, 0);
        spi_frame("w3", 32'h830F, 16, SYNC + 1, SYNC + 2, 0);
        spi_frame("addr5", 32'h85AA, 16, SYNC + 2, SYNC + 3, 0);
        spi_frame("read", 32'h00AA, 16, SYNC + 2, SYNC + 3, 0);
        spi_frame("short15", 32'h81AA >> 1, 15, SYNC + 1, SYNC + 3, 0);
        spi_frame("long17", {15'd0, 16'h81AA, 1'b1}, 17, SYNC + 1, SYNC + 3, 0);
        spi_frame("rst mid", 32'h82AA, 16, SYNC + 1, SYNC + 3, 8);
        spi_frame("after rst", 32'h8255, 16, SYNC + 1, SYNC + 2, 0);
        idle_toggle(6);

        for (int k = 0; k < 40; k++) begin
            r     = int'($urandom_range(0, 9));
            value = $urandom;
            if (r == 0)      nbits = 15;
            else if (r == 1) nbits = 17;
            else if (r == 2) nbits = int'($urandom_range(1, 20));
            else begin
                nbits        = 16;
                value[15]    = ($urandom_range(0, 3) != 0);
                value[14:8]  = 7'($urandom_range(0, 6));
            end
            half = ($urandom_range(0, 1) != 0) ? SYNC + 1 : int'($urandom_range(SYNC + 1, SYNC + 4));
            gap  = ($urandom_range(0, 1) != 0) ? SYNC + 2 : int'($urandom_range(SYNC + 2, SYNC + 6));
            spi_frame($sformatf("rnd%0d", k), value, nbits, half, gap, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
